// File: rtl/rca_pkg.sv
// rca_pkg: shared definitions for the registered ripple-carry adder.
//   RCA_DWIDTH_DEFAULT : default operand / sum width in bits.
//   rca_op_t           : one operand set {a, b, ci} at the default width.
//   rca_golden()       : reference result {co, s} at the default width.
//                        Computed arithmetically and used only outside the
//                        datapath.
package rca_pkg;

  localparam int RCA_DWIDTH_DEFAULT = 8;

  typedef struct packed {
    logic [RCA_DWIDTH_DEFAULT-1:0] a;
    logic [RCA_DWIDTH_DEFAULT-1:0] b;
    logic                          ci;
  } rca_op_t;

  // Full-precision result: bit RCA_DWIDTH_DEFAULT is the carry-out.
  function automatic logic [RCA_DWIDTH_DEFAULT:0] rca_golden(
    input logic [RCA_DWIDTH_DEFAULT-1:0] a,
    input logic [RCA_DWIDTH_DEFAULT-1:0] b,
    input logic                          ci
  );
    logic [RCA_DWIDTH_DEFAULT:0] a_ext;
    logic [RCA_DWIDTH_DEFAULT:0] b_ext;
    logic [RCA_DWIDTH_DEFAULT:0] ci_ext;
    a_ext  = {1'b0, a};
    b_ext  = {1'b0, b};
    ci_ext = {{RCA_DWIDTH_DEFAULT{1'b0}}, ci};
    return a_ext + b_ext + ci_ext;
  endfunction

endpackage

// File: rtl/rca_fa.sv
// rca_fa: 1-bit combinational full adder, the cell of the ripple chain.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module rca_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // The propagate term is shared by the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rca_adder.sv
// rca_adder: registered ripple-carry adder, {co_o, s_o} = a_i + b_i + ci_i.
// Operands are registered, then run through a DWIDTH-long chain of rca_fa
// cells, and the result is registered. Latency is 2 cycles and throughput
// is 1 result per clock.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   a_i     : operand A (DWIDTH, unsigned)
//   b_i     : operand B (DWIDTH, unsigned)
//   ci_i    : carry in
//   valid_i : operands valid this cycle
//   s_o     : registered sum (DWIDTH)
//   co_o    : registered carry out
//   valid_o : one-cycle pulse per new result
module rca_adder
  import rca_pkg::*;
#(
  parameter int DWIDTH = RCA_DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  input  logic              ci_i,
  input  logic              valid_i,
  output logic [DWIDTH-1:0] s_o,
  output logic              co_o,
  output logic              valid_o
);

  // Same layout as rca_op_t, but sized by DWIDTH.
  typedef struct packed {
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic              ci;
  } op_t;

  op_t               op_q, op_d;
  logic              valid1_q, valid1_d;
  logic [DWIDTH:0]   carry;
  logic [DWIDTH-1:0] sum;
  logic [DWIDTH-1:0] s_q, s_d;
  logic              co_q, co_d;
  logic              valid_o_q, valid_o_d;

  // Stage 1: operands only load on valid_i. This keeps idle-cycle X values
  // out of the datapath.
  always_comb begin
    op_d     = op_q;
    valid1_d = valid_i;
    if (valid_i) begin
      op_d.a  = a_i;
      op_d.b  = b_i;
      op_d.ci = ci_i;
    end
  end

  // Ripple chain, LSB to MSB.
  assign carry[0] = op_q.ci;

  for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_fa
    rca_fa u_fa (
      .a  (op_q.a[gi]),
      .b  (op_q.b[gi]),
      .ci (carry[gi]),
      .s  (sum[gi]),
      .co (carry[gi+1])
    );
  end

  // Stage 2: load on a valid stage-1 flag, otherwise hold the last result.
  always_comb begin
    s_d       = s_q;
    co_d      = co_q;
    valid_o_d = valid1_q;
    if (valid1_q) begin
      s_d  = sum;
      co_d = carry[DWIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      valid1_q  <= 1'b0;
      s_q       <= '0;
      co_q      <= 1'b0;
      valid_o_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      valid1_q  <= valid1_d;
      s_q       <= s_d;
      co_q      <= co_d;
      valid_o_q <= valid_o_d;
    end
  end

  assign s_o     = s_q;
  assign co_o    = co_q;
  assign valid_o = valid_o_q;

endmodule

// File: tb/tb_rca_adder.sv
// tb_rca_adder: directed and randomized bench for rca_adder at DWIDTH=8.
// The reference model records the arithmetic result of every operand set
// sampled on a clock edge. It expects that result, with valid_o=1, one edge
// later. Between results it expects the previous sum to be held.
module tb_rca_adder;
  import rca_pkg::*;

  localparam int W = RCA_DWIDTH_DEFAULT;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         ci_i;
  logic         valid_i;
  logic [W-1:0] s_o;
  logic         co_o;
  logic         valid_o;

  rca_adder #(.DWIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_i     (a_i),
    .b_i     (b_i),
    .ci_i    (ci_i),
    .valid_i (valid_i),
    .s_o     (s_o),
    .co_o    (co_o),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state.
  logic         pend_v;
  logic [W:0]   pend_r;
  logic         exp_v;
  logic [W:0]   exp_r;

  // Coverage tallies.
  int cov_ci0, cov_ci1, cov_co0, cov_co1;
  int cov_a0, cov_aff, cov_amid, cov_b0, cov_bff, cov_bmid;
  int valid_seen;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic model_reset();
    pend_v = 1'b0;
    pend_r = '0;
    exp_v  = 1'b0;
    exp_r  = '0;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic v);
    a_i     = a;
    b_i     = b;
    ci_i    = ci;
    valid_i = v;
  endtask

  // One clock: record what the edge samples, then check the outputs 1 ns later.
  task automatic cycle(input string tag);
    logic       v_in;
    logic [W:0] r_in;
    v_in = valid_i && rst_n;
    r_in = rca_golden(a_i, b_i, ci_i);
    @(posedge clk);
    #1;
    exp_v = pend_v;
    if (pend_v) exp_r = pend_r;
    pend_v = v_in;
    pend_r = r_in;
    if (valid_o === 1'b1) valid_seen++;
    chk({tag, "_valid"}, {{W{1'b0}}, valid_o}, {{W{1'b0}}, exp_v});
    chk({tag, "_result"}, {co_o, s_o}, exp_r);
  endtask

  // Apply one operand set, then check the DUT against a constant result.
  task automatic apply_one(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic ci,
                           input logic [W:0] expv);
    drive(a, b, ci, 1'b1);
    cycle(tag);
    drive('x, 'x, 1'bx, 1'b0);
    cycle(tag);
    chk({tag, "_const"}, {co_o, s_o}, expv);
    $display("txn %s a=%h b=%h ci=%0d -> co=%0d s=%h valid=%0d", tag, a, b, ci, co_o, s_o, valid_o);
    cycle({tag, "_drop"});
  endtask

  initial begin
    rca_op_t    ops[$];
    rca_op_t    op;
    logic [W:0] r;
    model_reset();
    {cov_ci0, cov_ci1, cov_co0, cov_co1} = '0;
    {cov_a0, cov_aff, cov_amid, cov_b0, cov_bff, cov_bmid} = '0;
    valid_seen = 0;

    // Reset state.
    rst_n = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    #2;
    chk("reset_state", {co_o, s_o}, '0);
    chk("reset_valid", {{W{1'b0}}, valid_o}, '0);
    cycle("reset_hold");
    #2 rst_n = 1'b1;

    // Directed test-plan cases.
    apply_one("zero",      8'h00, 8'h00, 1'b0, 9'h000);
    apply_one("carry_all", 8'hFF, 8'h01, 1'b0, 9'h100);
    apply_one("ci_only",   8'h00, 8'h00, 1'b1, 9'h001);
    apply_one("max",       8'hFF, 8'hFF, 1'b1, 9'h1FF);
    apply_one("mid",       8'd100, 8'd27, 1'b1, 9'd128);

    // Stream 10 back-to-back operand sets, then go idle with X on the operands.
    for (int i = 0; i < 10; i++) begin
      op.a  = W'($urandom);
      op.b  = W'($urandom);
      op.ci = 1'($urandom);
      ops.push_back(op);
    end
    valid_seen = 0;
    foreach (ops[i]) begin
      drive(ops[i].a, ops[i].b, ops[i].ci, 1'b1);
      cycle("stream");
    end
    drive('x, 'x, 1'bx, 1'b0);
    for (int i = 0; i < 3; i++) cycle("stream_tail");
    // The first stream result appears on the second edge of the stream, so the
    // window of 13 edges ends with 9 results plus 1 during the tail.
    chk("stream_count", 9'(valid_seen), 9'd10);
    r = rca_golden(ops[9].a, ops[9].b, ops[9].ci);
    chk("stream_last_hold", {co_o, s_o}, r);
    $display("txn stream 10 results, last co=%0d s=%h", co_o, s_o);

    // Reset between the sampling edge and the result edge.
    drive(8'h80, 8'h80, 1'b0, 1'b1);
    cycle("pre_rst");
    drive('0, '0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_result", {co_o, s_o}, '0);
    chk("rst_async_valid", {{W{1'b0}}, valid_o}, '0);
    model_reset();
    cycle("rst_no_pulse");
    #2 rst_n = 1'b1;
    cycle("post_rst_idle");
    $display("txn reset mid-operation co=%0d s=%h valid=%0d", co_o, s_o, valid_o);
    apply_one("post_rst", 8'h12, 8'h34, 1'b1, 9'h047);

    // Random regression with valid_i toggling randomly.
    for (int i = 0; i < 1200; i++) begin
      logic [W-1:0] a, b;
      logic         ci, v;
      case ($urandom_range(0, 3))
        0:       a = 8'h00;
        1:       a = 8'hFF;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       b = 8'h00;
        1:       b = 8'hFF;
        default: b = W'($urandom);
      endcase
      ci = 1'($urandom);
      v  = 1'($urandom);
      if (v) begin
        r = rca_golden(a, b, ci);
        if (ci) cov_ci1++; else cov_ci0++;
        if (r[W]) cov_co1++; else cov_co0++;
        if (a == 8'h00) cov_a0++; else if (a == 8'hFF) cov_aff++; else cov_amid++;
        if (b == 8'h00) cov_b0++; else if (b == 8'hFF) cov_bff++; else cov_bmid++;
        drive(a, b, ci, 1'b1);
      end else begin
        drive('x, 'x, 1'bx, 1'b0);
      end
      cycle("random");
    end
    drive('0, '0, 1'b0, 1'b0);
    cycle("random_tail");
    cycle("random_tail");
    $display("txn random coverage ci0=%0d ci1=%0d co0=%0d co1=%0d a0=%0d aff=%0d amid=%0d b0=%0d bff=%0d bmid=%0d",
             cov_ci0, cov_ci1, cov_co0, cov_co1, cov_a0, cov_aff, cov_amid, cov_b0, cov_bff, cov_bmid);
    chk("cov_ci", 9'((cov_ci0 > 0) && (cov_ci1 > 0)), 9'd1);
    chk("cov_co", 9'((cov_co0 > 0) && (cov_co1 > 0)), 9'd1);
    chk("cov_a",  9'((cov_a0 > 0) && (cov_aff > 0) && (cov_amid > 0)), 9'd1);
    chk("cov_b",  9'((cov_b0 > 0) && (cov_bff > 0) && (cov_bmid > 0)), 9'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
